// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD receive packer slice.
package sdc_pkg;

  // Packer control states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_WAIT_END = 2'd2
  } state_t;

  localparam int unsigned LANE_W     = 2;
  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned WORD_W     = 32;

  // Bit positions of the per-block status flags in the software status register
  localparam int unsigned STAT_CRC_BIT   = 0;
  localparam int unsigned STAT_FRAME_BIT = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_TMO_BIT   = 3;

  // One FIFO entry: byte-valid mask above a little-endian data word
  typedef struct packed {
    logic [BYTE_LANES-1:0] keep;
    logic [WORD_W-1:0]     data;
  } fifoEntry_t;

  localparam int unsigned ENTRY_W = $bits(fifoEntry_t);

endpackage

// File: rtl/sdc_word_fifo.sv
// First-word-fall-through FIFO for packed words; head reads as zero when empty.
module sdc_word_fifo #(
  parameter int unsigned DEPTH_W = 4,
  parameter int unsigned WIDTH   = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_W:0] wrPtr;
  logic [DEPTH_W:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[DEPTH_W] != rdPtr[DEPTH_W]) &&
                    (wrPtr[DEPTH_W-1:0] == rdPtr[DEPTH_W-1:0]);
  assign doPop    = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign doPush   = push && (!full || doPop);
  assign headData = empty ? '0 : mem[rdPtr[DEPTH_W-1:0]];

  // Pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (DEPTH_W+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (DEPTH_W+1)'(1);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[DEPTH_W-1:0]] <= pushData;
  end

endmodule

// File: rtl/sdc_rx_packer.sv
// Packs the SD receiver byte stream into 32-bit LE words and reports per-block status.
// Optional feature: define SDC_RX_TIMEOUT_EN to end a block when rx_idle never arrives.
module sdc_rx_packer
  import sdc_pkg::*;
#(
  parameter int unsigned BLKSIZE_W = 12,
  parameter int unsigned DEPTH_W   = 4
`ifdef SDC_RX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 rx_crc_err,
  input  logic                 rx_frame_err,
  input  logic                 rx_idle,
  output logic [31:0]          rd_data,
  output logic [3:0]           rd_keep,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 blk_done,
  output logic                 blk_crc_err,
  output logic                 blk_frame_err,
  output logic                 blk_overflow,
  output logic                 blk_timeout,
  output logic [BLKSIZE_W:0]   blk_bytes,
  output logic                 busy
);

  localparam int unsigned CNT_W = BLKSIZE_W + 1;

  state_t            state;
  logic [LANE_W-1:0] lane;
  logic [31:0]       packData;
  logic [3:0]        packKeep;
  logic [CNT_W-1:0]  byteCnt;
  logic [CNT_W-1:0]  cntInc;
  logic              crcAcc;
  logic              frmAcc;
  logic              ovfAcc;
  fifoEntry_t        pushEntry;
  fifoEntry_t        headEntry;
  logic              byteTake;
  logic              wordDone;
  logic              dropWord;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              tmoHit;

  assign byteTake = in_valid && (state != ST_WAIT_END);
  assign wordDone = byteTake && ((lane == LANE_W'(3)) || in_last);
  // The head is poppable whenever the FIFO is full, so rd_ready decides the drop
  assign dropWord = wordDone && fifoFull && !rd_ready;
  assign cntInc   = (byteCnt == '1) ? byteCnt : byteCnt + CNT_W'(1);
  assign busy     = (state != ST_IDLE);
  assign rd_valid = !fifoEmpty;
  assign rd_data  = headEntry.data;
  assign rd_keep  = headEntry.keep;

  // Current partial word with the incoming byte merged into its lane
  always_comb begin
    pushEntry.data = packData;
    pushEntry.keep = packKeep;
    pushEntry.data[{lane, 3'b000} +: 8] = in_data;
    pushEntry.keep[lane] = 1'b1;
  end

  // Lane counter and partial-word register; cleared each time a word leaves
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane     <= '0;
      packData <= '0;
      packKeep <= '0;
    end else if (wordDone) begin
      lane     <= '0;
      packData <= '0;
      packKeep <= '0;
    end else if (byteTake) begin
      lane     <= lane + LANE_W'(1);
      packData <= pushEntry.data;
      packKeep <= pushEntry.keep;
    end
  end

`ifdef SDC_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmoCnt;

  assign tmoHit = (state == ST_WAIT_END) && !rx_idle &&
                  (tmoCnt == TMO_W'(TIMEOUT_CYC - 1));

  // Cycles spent waiting for the receiver to go idle
  always_ff @(posedge clk) begin
    if (!rst_n || (state != ST_WAIT_END)) tmoCnt <= '0;
    else                                  tmoCnt <= tmoCnt + TMO_W'(1);
  end
`else
  assign tmoHit = 1'b0;
`endif

  // Block FSM: byte counting, status accumulation and the end-of-block report
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      byteCnt       <= '0;
      crcAcc        <= 1'b0;
      frmAcc        <= 1'b0;
      ovfAcc        <= 1'b0;
      blk_done      <= 1'b0;
      blk_crc_err   <= 1'b0;
      blk_frame_err <= 1'b0;
      blk_overflow  <= 1'b0;
      blk_timeout   <= 1'b0;
      blk_bytes     <= '0;
    end else begin
      blk_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state   <= in_last ? ST_WAIT_END : ST_COLLECT;
            byteCnt <= CNT_W'(1);
            crcAcc  <= 1'b0;
            frmAcc  <= 1'b0;
            ovfAcc  <= dropWord;
          end
        end
        ST_COLLECT: begin
          if (in_valid) begin
            byteCnt <= cntInc;
            if (dropWord) ovfAcc <= 1'b1;
            if (in_last)  state  <= ST_WAIT_END;
          end
        end
        ST_WAIT_END: begin
          crcAcc <= crcAcc | rx_crc_err;
          // A byte arriving after in_last is discarded and counted as a framing fault
          frmAcc <= frmAcc | rx_frame_err | in_valid;
          if (rx_idle || tmoHit) begin
            state         <= ST_IDLE;
            blk_done      <= 1'b1;
            blk_crc_err   <= crcAcc | rx_crc_err;
            blk_frame_err <= frmAcc | rx_frame_err | in_valid;
            blk_overflow  <= ovfAcc;
            blk_timeout   <= tmoHit;
            blk_bytes     <= byteCnt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sdc_word_fifo #(
    .DEPTH_W (DEPTH_W),
    .WIDTH   (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wordDone),
    .pushData (pushEntry),
    .pop      (rd_ready),
    .headData (headEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_sdc_rx_packer.sv
// Scoreboard bench for sdc_rx_packer: expected words/status queued at stimulus, checked by a monitor.
module tb_sdc_rx_packer;

  localparam int BLKSIZE_W = 12;
  localparam int DEPTH_W   = 4;
  localparam int FIFO_WORDS = 1 << DEPTH_W;
  localparam int BYTES_MAX = (1 << (BLKSIZE_W + 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 rx_crc_err;
  logic                 rx_frame_err;
  logic                 rx_idle;
  logic [31:0]          rd_data;
  logic [3:0]           rd_keep;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 blk_done;
  logic                 blk_crc_err;
  logic                 blk_frame_err;
  logic                 blk_overflow;
  logic                 blk_timeout;
  logic [BLKSIZE_W:0]   blk_bytes;
  logic                 busy;

  typedef struct { logic [31:0] data; logic [3:0] keep; } word_t;
  typedef struct { bit crc; bit frm; bit ovf; bit tmo; int bytes; } stat_t;

  word_t expWords[$];
  stat_t expStats[$];
  int    tests = 0;
  int    fails = 0;
  int    rdMode = 1;   // 0 hold low, 1 always ready, 2 random

  sdc_rx_packer #(.BLKSIZE_W(BLKSIZE_W), .DEPTH_W(DEPTH_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .rx_crc_err    (rx_crc_err),
    .rx_frame_err  (rx_frame_err),
    .rx_idle       (rx_idle),
    .rd_data       (rd_data),
    .rd_keep       (rd_keep),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .blk_done      (blk_done),
    .blk_crc_err   (blk_crc_err),
    .blk_frame_err (blk_frame_err),
    .blk_overflow  (blk_overflow),
    .blk_timeout   (blk_timeout),
    .blk_bytes     (blk_bytes),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sink-side ready pattern
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rd_ready = (rdMode == 1) ? 1'b1 : (rdMode == 2) ? 1'($urandom_range(1)) : 1'b0;
    end
  end

  // Monitor: compare every popped word and every block report against the queues
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rd_valid && rd_ready) begin
        if (expWords.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word: got 0x%0h keep 0x%0h, expected none", rd_data, rd_keep);
        end else begin
          word_t w;
          w = expWords.pop_front();
          check("word_data", 64'(rd_data), 64'(w.data));
          check("word_keep", 64'(rd_keep), 64'(w.keep));
        end
      end
      if (blk_done) begin
        if (expStats.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_blk_done: got 1, expected 0 at %0t", $time);
        end else begin
          stat_t s;
          s = expStats.pop_front();
          check("blk_crc_err",   64'(blk_crc_err),   64'(s.crc));
          check("blk_frame_err", 64'(blk_frame_err), 64'(s.frm));
          check("blk_overflow",  64'(blk_overflow),  64'(s.ovf));
          check("blk_timeout",   64'(blk_timeout),   64'(s.tmo));
          check("blk_bytes",     64'(blk_bytes),     64'(s.bytes));
        end
      end
    end
  end

  // Reference: word k holds bytes 4k..4k+3, byte j of the word at bits 8j+7:8j
  task automatic queueWords(input bit [7:0] q[$], input int keepWords);
    int n = q.size();
    int nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      word_t w;
      w.data = '0;
      w.keep = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < n) begin
          w.data = w.data | (32'(q[4 * k + j]) << (8 * j));
          w.keep = w.keep | 4'(1 << j);
        end
      end
      if (keepWords < 0 || k < keepWords) expWords.push_back(w);
    end
  endtask

  task automatic sendBytes(input bit [7:0] q[$], input int gapPct, input bit withLast);
    for (int i = 0; i < q.size(); i++) begin
      while ($urandom_range(99) < gapPct) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = q[i];
      in_last  = withLast && (i == q.size() - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full block: bytes, a status-wait window with per-cycle error patterns, then rx_idle
  task automatic runBlock(input bit [7:0] q[$], input int gapPct, input int waitCyc,
                          input bit [15:0] crcMask, input bit [15:0] frmMask,
                          input bit extra, input int keepWords);
    stat_t s;
    queueWords(q, keepWords);
    s.crc   = 0;
    s.frm   = extra;
    s.ovf   = (keepWords >= 0);
    s.tmo   = 0;
    s.bytes = (q.size() > BYTES_MAX) ? BYTES_MAX : q.size();
    rx_idle = 1'b0;
    sendBytes(q, gapPct, 1'b1);
    for (int c = 0; c < waitCyc; c++) begin
      rx_crc_err   = crcMask[c];
      rx_frame_err = frmMask[c];
      s.crc = s.crc | crcMask[c];
      s.frm = s.frm | frmMask[c];
      in_valid = extra && (c == 0);
      in_data  = 8'hEE;
      step();
      in_valid = 1'b0;
    end
    rx_crc_err   = 1'b0;
    rx_frame_err = 1'b0;
    expStats.push_back(s);
    rx_idle = 1'b1;
    step();
  endtask

  task automatic waitDrain(input string name);
    int t = 0;
    while ((expWords.size() != 0 || expStats.size() != 0) && t < 5000) begin
      step();
      t++;
    end
    tests++;
    if (expWords.size() != 0 || expStats.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d words %0d reports pending, expected 0", name,
               expWords.size(), expStats.size());
      expWords.delete();
      expStats.delete();
    end
  endtask

  initial begin
    bit [7:0] q[$];
    int n, wc;
    bit extra;

    rst_n = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    rx_crc_err = 1'b0; rx_frame_err = 1'b0; rx_idle = 1'b1;
    repeat (3) step();
    check("reset_rd_valid",  64'(rd_valid),  64'(0));
    check("reset_rd_data",   64'(rd_data),   64'(0));
    check("reset_rd_keep",   64'(rd_keep),   64'(0));
    check("reset_blk_done",  64'(blk_done),  64'(0));
    check("reset_blk_bytes", 64'(blk_bytes), 64'(0));
    check("reset_busy",      64'(busy),      64'(0));
    rst_n = 1'b1;
    step();

    // 512 bytes, 0x00..0xFF twice, clean status
    q.delete();
    for (int i = 0; i < 512; i++) q.push_back(8'(i));
    rdMode = 1;
    runBlock(q, 0, 2, 16'h0, 16'h0, 1'b0, -1);
    waitDrain("blk512");

    // 6-byte block with a 2-byte tail
    q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    runBlock(q, 20, 1, 16'h0, 16'h0, 1'b0, -1);
    waitDrain("blk6");

    // CRC in first wait cycle, frame error in the second, then idle
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    runBlock(q, 0, 3, 16'b001, 16'b010, 1'b0, -1);
    waitDrain("crc_frame");
    q = '{8'h66, 8'h77, 8'h88};
    runBlock(q, 0, 3, 16'h0, 16'h0, 1'b0, -1);
    waitDrain("clean_after_err");

    // Overflow: sink stalled, 80 bytes -> 16 stored, 4 dropped
    q.delete();
    for (int i = 0; i < 80; i++) q.push_back(8'($urandom));
    rdMode = 0;
    step();
    runBlock(q, 0, 1, 16'h0, 16'h0, 1'b0, FIFO_WORDS);
    repeat (3) step();
    check("ovf_fifo_full_held", 64'(rd_valid), 64'(1));
    rdMode = 1;
    waitDrain("overflow");

    // Byte after in_last is dropped and flagged as a framing fault
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    runBlock(q, 0, 2, 16'h0, 16'h0, 1'b1, -1);
    waitDrain("late_byte");

    // Reset in the middle of a block
    q = '{8'hDE, 8'hAD, 8'hBE};
    rx_idle = 1'b0;
    sendBytes(q, 0, 1'b0);
    check("mid_busy_before_reset", 64'(busy), 64'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_reset_rd_valid",  64'(rd_valid),      64'(0));
    check("mid_reset_busy",      64'(busy),          64'(0));
    check("mid_reset_blk_bytes", 64'(blk_bytes),     64'(0));
    check("mid_reset_frame",     64'(blk_frame_err), 64'(0));
    repeat (4) step();
    check("mid_reset_no_done",   64'(blk_done),      64'(0));
    q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    runBlock(q, 0, 1, 16'h0, 16'h0, 1'b0, -1);
    waitDrain("after_reset");

    // Randomized short blocks with random sink stalls and status noise
    rdMode = 2;
    for (int b = 0; b < 30; b++) begin
      n = $urandom_range(60, 1);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      wc = $urandom_range(8, 0);
      extra = (b % 7 == 3);
      if (extra && wc == 0) wc = 1;
      runBlock(q, 30, wc, 16'($urandom), 16'($urandom), extra, -1);
      repeat ($urandom_range(3)) step();
      waitDrain("random");
    end

    // Byte count saturation
    rdMode = 1;
    q.delete();
    for (int i = 0; i < BYTES_MAX + 1; i++) q.push_back(8'(i * 7));
    runBlock(q, 0, 2, 16'h0, 16'h0, 1'b0, -1);
    waitDrain("saturate");

`ifdef SDC_RX_TIMEOUT_EN
    // rx_idle never rises: report exactly 64 cycles after WAIT_END entry
    begin
      stat_t s;
      q = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
      queueWords(q, -1);
      s.crc = 0; s.frm = 0; s.ovf = 0; s.tmo = 1; s.bytes = 4;
      rx_idle = 1'b0;
      sendBytes(q, 0, 1'b1);
      expStats.push_back(s);
      for (int c = 1; c <= 64; c++) begin
        step();
        if (c == 63) check("tmo_not_early", 64'(blk_done), 64'(0));
        if (c == 64) check("tmo_done_at_64", 64'(blk_done), 64'(1));
      end
      rx_idle = 1'b1;
      waitDrain("timeout");
    end
`endif

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
